pattern_player: RTL and testbench

PATTERN_PLAYER -- requirements
Module: pattern_player

---
 rtl/mem_pkg.sv | 24 ++
 rtl/cycle_timer.sv | 29 ++
 rtl/pattern_player.sv | 158 +++++++++++++++
 tb/tb_pattern_player.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-game blocks.
//   play_state_e    : playback FSM states (IDLE/SHOW/GAP/FINISH)
//   MAX_PATTERN_LEN : longest pattern the game can hold
//   clamp_len()     : limits a score-counter length to MAX_PATTERN_LEN
package mem_pkg;

  localparam int unsigned MAX_PATTERN_LEN = 32;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap,
    StFinish
  } play_state_e;

  // Lengths above the pattern capacity play the full pattern.
  function automatic logic [5:0] clamp_len(input logic [15:0] len);
    if (len > 16'(MAX_PATTERN_LEN)) begin
      return 6'(MAX_PATTERN_LEN);
    end
    return len[5:0];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// 8-bit duration down-counter. A load takes priority and sets the count to
// value; otherwise the count decrements and holds at zero (never wraps).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load value this cycle
//   value      : count to load
//   expired    : count is zero
module cycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/pattern_player.sv
// Plays back a captured game pattern on two LEDs, oldest bit first. Each bit
// is shown for ON_CYCLES cycles (led_1 = bit, led_0 = ~bit) followed by
// GAP_CYCLES dark cycles; a one-cycle done pulse marks normal completion.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : playback request, honoured only in IDLE
//   pattern      : pattern shift register, newest bit at [0]
//   length       : number of bits to play (clamped to 32)
//   clr          : synchronous abort to IDLE, beats start
//   led_0, led_1 : displayed bit is 0 / 1
//   busy         : high during SHOW and GAP
//   done         : one-cycle pulse after the last gap
import mem_pkg::*;

module pattern_player #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] pattern,
  input  logic [15:0] length,
  input  logic        clr,
  output logic        led_0,
  output logic        led_1,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] OnLoad  = 8'(ON_CYCLES - 1);
  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  play_state_e state_q;
  logic [31:0] pat_q;
  logic [4:0]  idx_q;
  logic        led_0_q, led_1_q, busy_q, done_q;

  logic [5:0]  start_len;
  logic [4:0]  first_idx;
  logic [4:0]  next_idx;
  logic        timer_load;
  logic [7:0]  timer_value;
  logic        timer_expired;

  assign start_len = clamp_len(length);
  assign first_idx = 5'(start_len - 6'd1);
  assign next_idx  = idx_q - 5'd1;

  // Timer is loaded on the same edge that enters SHOW or GAP, so the loaded
  // value is one less than the number of cycles spent in that state.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = 8'd0;
    if (clr) begin
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (start_len != 6'd0)) begin
            timer_load  = 1'b1;
            timer_value = OnLoad;
          end
        end
        StShow: begin
          if (timer_expired) begin
            timer_load  = 1'b1;
            timer_value = GapLoad;
          end
        end
        StGap: begin
          if (timer_expired && (idx_q != 5'd0)) begin
            timer_load  = 1'b1;
            timer_value = OnLoad;
          end
        end
        default: ;
      endcase
    end
  end

  cycle_timer u_cycle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pat_q   <= 32'd0;
      idx_q   <= 5'd0;
      led_0_q <= 1'b0;
      led_1_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clr) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      led_0_q <= 1'b0;
      led_1_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            pat_q <= pattern;
            if (start_len == 6'd0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StShow;
              idx_q   <= first_idx;
              busy_q  <= 1'b1;
              led_1_q <= pattern[first_idx];
              led_0_q <= ~pattern[first_idx];
            end
          end
        end
        StShow: begin
          if (timer_expired) begin
            state_q <= StGap;
            led_0_q <= 1'b0;
            led_1_q <= 1'b0;
          end
        end
        StGap: begin
          if (timer_expired) begin
            if (idx_q == 5'd0) begin
              state_q <= StFinish;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StShow;
              idx_q   <= next_idx;
              led_1_q <= pat_q[next_idx];
              led_0_q <= ~pat_q[next_idx];
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign led_0 = led_0_q;
  assign led_1 = led_1_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: each playback is predicted as a per-cycle trace
// of {led_0, led_1, busy, done} built from the playback rules, then compared
// cycle by cycle. Optional mid-run disturbance (start/pattern/length change)
// and abort (clr or reset) are applied at a chosen trace cycle.
module tb_pattern_player;

  localparam int unsigned OnC  = 4;
  localparam int unsigned GapC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pattern = 32'd0;
  logic [15:0] length = 16'd0;
  logic        clr = 1'b0;
  logic        led_0, led_1, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  pattern_player #(
    .ON_CYCLES  (OnC),
    .GAP_CYCLES (GapC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .length  (length),
    .clr     (clr),
    .led_0   (led_0),
    .led_1   (led_1),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {led0,led1,busy,done}=%b, want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {led_0, led_1, busy, done};
  endfunction

  // abort_kind: 0 none, 1 clr at cycle abort_at, 2 reset at cycle abort_at
  task automatic play(input string tag, input logic [31:0] pat, input logic [15:0] len,
                      input int disturb_at, input int abort_kind, input int abort_at);
    logic [3:0] exp_q[$];
    int l;
    logic b;
    l = (len > 16'd32) ? 32 : int'(len);
    for (int k = 0; k < l; k++) begin
      b = pat[l - 1 - k];
      for (int c = 0; c < int'(OnC); c++) exp_q.push_back({~b, b, 1'b1, 1'b0});
      for (int c = 0; c < int'(GapC); c++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);

    @(negedge clk);
    start = 1'b1;
    pattern = pat;
    length = len;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (abort_kind == 2 && c == abort_at) begin
        rst_n = 1'b0;
        #1 check({tag, " rst-now"}, outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      start = (c == disturb_at);
      if (c == disturb_at) begin
        pattern = $urandom;
        length = 16'($urandom);
      end
      check(tag, outs(), exp_q[c]);
      if (abort_kind == 1 && c == abort_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    // After completion or abort the block must sit dark in IDLE.
    for (int c = 0; c < 4; c++) begin
      check({tag, " idle"}, outs(), 4'b0000);
      @(negedge clk);
    end
  endtask

  initial begin
    #2 check("reset", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle-after-reset", outs(), 4'b0000);

    play("two-bits", 32'h0000_0002, 16'd2, -1, 0, 0);
    play("len-zero", 32'hFFFF_FFFF, 16'd0, -1, 0, 0);
    play("len-40", 32'h8000_0001, 16'd40, -1, 0, 0);
    play("clr-3rd-show", 32'h0000_0005, 16'd3, -1, 1, 2);
    play("after-clr", 32'h0000_0005, 16'd3, -1, 0, 0);
    play("restart-ignored", 32'h0000_00A5, 16'd8, 7, 0, 0);
    play("rst-in-gap", 32'h0000_0002, 16'd2, -1, 2, 4);
    play("after-rst", 32'h0000_0001, 16'd1, -1, 0, 0);
    play("len-32", 32'hDEAD_BEEF, 16'd32, -1, 0, 0);
    play("len-ffff", 32'h1234_5678, 16'hFFFF, 40, 0, 0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] p;
      logic [15:0] n;
      int kind;
      int span;
      p = $urandom;
      n = 16'($urandom_range(0, 40));
      span = ((n > 16'd32) ? 32 : int'(n)) * int'(OnC + GapC) + 1;
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      play("random", p, n, int'($urandom_range(0, span)), kind,
           int'($urandom_range(0, span - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
